// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: free-running counter plus
// CHANNELS independent periodic/one-shot clock-enable pulse channels.
module tick_gen_chan #(
  parameter int          WIDTH          = 32,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_period,
  output logic             tick,
  output logic             armed
);
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

  logic [WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
  logic             tick_q, tick_d, armed_q, armed_d;
  logic             active, terminal;

  // A zero period never matches terminal because active is gated on it.
  assign active   = run & armed_q & (period_q != '0);
  assign terminal = (cnt_q == period_q - WIDTH'(1));

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    tick_d   = 1'b0;
    if (load) begin
      // Load wins over a coincident terminal count; that tick is dropped.
      period_d = load_period;
      cnt_d    = '0;
      armed_d  = 1'b1;
    end else if (active) begin
      if (terminal) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (oneshot) armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= DEF_P;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      tick_q   <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign armed = armed_q;
endmodule

module tick_gen #(
  parameter int          WIDTH          = 32,
  parameter int          CHANNELS       = 4,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [CHANNELS-1:0] oneshot,
  input  logic                load,
  input  logic [3:0]          load_ch,
  input  logic [WIDTH-1:0]    load_period,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] armed,
  output logic [WIDTH-1:0]    free_cnt
);
  logic [WIDTH-1:0]    free_cnt_q, free_cnt_d;
  logic [CHANNELS-1:0] load_hit;

  assign free_cnt_d = free_cnt_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) free_cnt_q <= '0;
    else     free_cnt_q <= free_cnt_d;
  end

  assign free_cnt = free_cnt_q;

  // Out-of-range load_ch matches no channel, so such a load is a no-op.
  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      assign load_hit[i] = load & (load_ch == 4'(i));

      tick_gen_chan #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .run         (en & ch_en[i]),
        .oneshot     (oneshot[i]),
        .load        (load_hit[i]),
        .load_period (load_period),
        .tick        (tick[i]),
        .armed       (armed[i])
      );
    end
  endgenerate
endmodule
